// File: rtl/alu_muldiv_param_if.sv
// alu_muldiv_param_if
//   Bundles the EX-stage ALU signals of alu_muldiv_param.
//   master : pipeline side, drives the operands and the operation, reads the results
//   slave  : ALU side, reads the operands and the operation, drives the results
//   Operands : Valid, ALUOperation, A, B, Shamt, ProgramCounter, Offset
//   Results  : ALUResult, Zero, NotZero, JReg, Busy, Done, Stall, HI, LO
interface alu_muldiv_param_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               Valid;
  logic [3:0]         ALUOperation;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [SHAMT_W-1:0] Shamt;
  logic [WIDTH-1:0]   ProgramCounter;
  logic [15:0]        Offset;
  logic [WIDTH-1:0]   ALUResult;
  logic               Zero;
  logic               NotZero;
  logic               JReg;
  logic               Busy;
  logic               Done;
  logic               Stall;
  logic [WIDTH-1:0]   HI;
  logic [WIDTH-1:0]   LO;

  modport master (
    output Valid, ALUOperation, A, B, Shamt, ProgramCounter, Offset,
    input  ALUResult, Zero, NotZero, JReg, Busy, Done, Stall, HI, LO
  );

  modport slave (
    input  Valid, ALUOperation, A, B, Shamt, ProgramCounter, Offset,
    output ALUResult, Zero, NotZero, JReg, Busy, Done, Stall, HI, LO
  );
endinterface

// File: rtl/alu_muldiv_param.sv
// alu_muldiv_param
//   MIPS EX-stage ALU: the single-cycle ops are combinational, and an iterative
//   engine (shift-add multiply, restoring divide) writes the HI/LO registers.
//   Optional macro ALU_SIGNED_MULDIV_EN: MULT/DIV use two's-complement operands
//   and a FIX cycle applies the result signs.
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-low
//     bus   : alu_muldiv_param_if.slave (operands in; result, flags, Busy/Done/Stall, HI/LO out)
//
//   state | meaning
//   IDLE  | engine free, waiting for a valid MULT/DIV
//   RUN   | one multiply/divide bit per cycle, cnt counts down from WIDTH
//   FIX   | signed build only: apply the signs to the product/quotient/remainder
//   DONE  | Done pulse; HI/LO load on leaving this state
module alu_muldiv_param #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int ADDR_W  = 12
) (
  input logic              clk,
  input logic              reset,
  alu_muldiv_param_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
`ifdef ALU_SIGNED_MULDIV_EN
    S_FIX  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  // Multiply: acc_hi holds the running upper product and acc_lo holds the multiplier,
  // which shifts out as the product shifts in. Divide: acc_hi holds the remainder and
  // acc_lo holds the dividend, which shifts out as the quotient shifts in.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic             is_div;
  logic [CNT_W-1:0] cnt;
`ifdef ALU_SIGNED_MULDIV_EN
  logic             neg_a;
  logic             neg_b;
  logic [2*WIDTH-1:0] prod_neg;
`endif

  logic [WIDTH-1:0] alu_res;
  logic             is_muldiv_op;
  logic             is_hilo_op;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    alu_res = '0;
    case (bus.ALUOperation)
      4'd0:  alu_res = bus.A & bus.B;
      4'd1:  alu_res = bus.A | bus.B;
      4'd2:  alu_res = ~(bus.A | bus.B);
      4'd3:  alu_res = bus.A + bus.B;
      4'd4:  alu_res = bus.A - bus.B;
      4'd5:  alu_res = bus.B << bus.Shamt;
      4'd6:  alu_res = bus.B >> bus.Shamt;
      4'd7:  alu_res = bus.B << 16;
      4'd8:  alu_res = hi_q;
      4'd9:  alu_res = bus.ProgramCounter;
      4'd10: alu_res = '0;
      4'd11, 4'd12:
        alu_res = {{(WIDTH-ADDR_W){1'b0}}, ADDR_W'(bus.A + WIDTH'($signed(bus.Offset)))};
      4'd15: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  assign is_muldiv_op = (bus.ALUOperation == 4'd13) || (bus.ALUOperation == 4'd14);
  assign is_hilo_op   = is_muldiv_op || (bus.ALUOperation == 4'd8) || (bus.ALUOperation == 4'd15);

  assign bus.ALUResult = alu_res;
  assign bus.Zero      = (alu_res == '0);
  assign bus.NotZero   = (alu_res != '0);
  assign bus.JReg      = (bus.ALUOperation == 4'd10);
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  // MFHI/MFLO are held while the engine is busy, including its DONE cycle, so they
  // never read a stale HI/LO.
  assign bus.Stall     = bus.Valid & busy_q & is_hilo_op;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;

  // One shift-add multiply step and one restoring divide step.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  // When div_ge is set the true difference is below opnd, so the WIDTH-bit wrap is exact.
  assign div_diff  = div_shift[WIDTH-1:0] - opnd;

`ifdef ALU_SIGNED_MULDIV_EN
  assign mag_a    = bus.A[WIDTH-1] ? ('0 - bus.A) : bus.A;
  assign mag_b    = bus.B[WIDTH-1] ? ('0 - bus.B) : bus.B;
  assign prod_neg = '0 - {acc_hi, acc_lo};
`else
  assign mag_a = bus.A;
  assign mag_b = bus.B;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      cnt    <= '0;
`ifdef ALU_SIGNED_MULDIV_EN
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.Valid && is_muldiv_op) begin
            state  <= S_RUN;
            busy_q <= 1'b1;
            cnt    <= CNT_W'(WIDTH);
            is_div <= (bus.ALUOperation == 4'd14);
            acc_hi <= '0;
            acc_lo <= mag_a;
            opnd   <= mag_b;
`ifdef ALU_SIGNED_MULDIV_EN
            neg_a  <= bus.A[WIDTH-1];
            neg_b  <= bus.B[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          if (is_div && (opnd == '0)) begin
            // Divide by zero: LO all ones, HI the original dividend (no sign fix-up).
            acc_lo <= '1;
`ifdef ALU_SIGNED_MULDIV_EN
            acc_hi <= neg_a ? ('0 - acc_lo) : acc_lo;
`else
            acc_hi <= acc_lo;
`endif
            state  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            if (is_div) begin
              acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end else begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
            end
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
`ifdef ALU_SIGNED_MULDIV_EN
              state  <= S_FIX;
`else
              state  <= S_DONE;
              done_q <= 1'b1;
`endif
            end
          end
        end
`ifdef ALU_SIGNED_MULDIV_EN
        S_FIX: begin
          if (is_div) begin
            acc_lo <= (neg_a ^ neg_b) ? ('0 - acc_lo) : acc_lo;
            acc_hi <= neg_a ? ('0 - acc_hi) : acc_hi;
          end else if (neg_a ^ neg_b) begin
            {acc_hi, acc_lo} <= prod_neg;
          end
          state  <= S_DONE;
          done_q <= 1'b1;
        end
`endif
        S_DONE: begin
          hi_q   <= acc_hi;
          lo_q   <= acc_lo;
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_param.sv
// tb_alu_muldiv_param
//   Self-checking bench for alu_muldiv_param (WIDTH=32). Expected values come from a
//   behavioural model built on plain arithmetic. Define ALU_SIGNED_MULDIV_EN to
//   check the signed build.
module tb_alu_muldiv_param;

  localparam int W = 32;
`ifdef ALU_SIGNED_MULDIV_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_muldiv_param_if #(.WIDTH(W), .SHAMT_W(5)) bus ();

  alu_muldiv_param #(.WIDTH(W), .SHAMT_W(5), .ADDR_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b,
                                          input logic [4:0] sh, input logic [31:0] pc,
                                          input logic [15:0] off, input logic [31:0] hi, lo);
    int signed addr;
    addr = int'(a) + int'($signed(off));
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return ~(a | b);
      4'd3:  return a + b;
      4'd4:  return a - b;
      4'd5:  return b << sh;
      4'd6:  return b >> sh;
      4'd7:  return {b[15:0], 16'h0000};
      4'd8:  return hi;
      4'd9:  return pc;
      4'd11, 4'd12: return 32'(addr) % 32'd4096;
      4'd15: return lo;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void ref_engine(input logic [3:0] op, input logic [31:0] a, b,
                                     output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    if (op == 4'd14 && b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (op == 4'd13) begin
`ifdef ALU_SIGNED_MULDIV_EN
      p = 64'(longint'($signed(a)) * longint'($signed(b)));
`else
      p = {32'd0, a} * {32'd0, b};
`endif
      hi = p[63:32];
      lo = p[31:0];
    end else begin
`ifdef ALU_SIGNED_MULDIV_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = 32'h8000_0000;
        hi = 32'd0;
      end else begin
        lo = 32'($signed(a) / $signed(b));
        hi = 32'($signed(a) % $signed(b));
      end
`else
      lo = a / b;
      hi = a % b;
`endif
    end
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, b);
    bus.Valid = v;
    bus.ALUOperation = op;
    bus.A = a;
    bus.B = b;
  endtask

  // Issues one MULT/DIV and reports the cycle offset of the Done pulse and HI/LO
  // one cycle after it.
  task automatic run_engine(input logic [3:0] op, input logic [31:0] a, b,
                            output int lat, output logic [31:0] hi, output logic [31:0] lo,
                            output logic busy_after);
    @(posedge clk); #1;
    drive(1'b1, op, a, b);
    lat = -1;
    for (int k = 1; k <= LAT + 10; k++) begin
      @(posedge clk); #1;
      drive(1'b0, 4'd3, a, b);
      @(negedge clk);
      if (bus.Done) begin
        lat = k;
        break;
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    hi = bus.HI;
    lo = bus.LO;
    busy_after = bus.Busy;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(1'b1, 4'd13, $urandom, $urandom);
    bus.Shamt = 5'($urandom);
    bus.ProgramCounter = $urandom;
    bus.Offset = 16'($urandom);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      errors++; $display("FAIL reset_hilo got %h/%h want 0/0", bus.HI, bus.LO);
    end
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Stall !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b done=%b stall=%b want 0 0 0", bus.Busy, bus.Done, bus.Stall);
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus.ALUResult !== 32'd0 || bus.Zero !== 1'b1 || bus.NotZero !== 1'b0 || bus.JReg !== 1'b0) begin
      errors++; $display("FAIL reset_comb got res=%h z=%b nz=%b jr=%b want 0 1 0 0", bus.ALUResult, bus.Zero, bus.NotZero, bus.JReg);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 4'd3, 32'd5, 32'd7);
    @(negedge clk);
    checks++;
    if (bus.ALUResult !== 32'd12 || bus.Zero !== 1'b0 || bus.NotZero !== 1'b1) begin
      errors++; $display("FAIL add_5_7 got res=%h z=%b nz=%b want 0000000c 0 1", bus.ALUResult, bus.Zero, bus.NotZero);
    end
  endtask

  task automatic test_single_cycle;
    logic [3:0] op;
    logic [31:0] a, b, exp;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      @(posedge clk); #1;
      drive(1'b0, op, a, b);
      bus.Shamt = 5'($urandom);
      bus.ProgramCounter = $urandom;
      bus.Offset = 16'($urandom);
      exp = ref_alu(op, a, b, bus.Shamt, bus.ProgramCounter, bus.Offset, m_hi, m_lo);
      @(negedge clk);
      checks++;
      if (bus.ALUResult !== exp) begin
        errors++; $display("FAIL alu_op%0d got %h want %h", op, bus.ALUResult, exp);
      end
      checks++;
      if (bus.Zero !== (exp == 0) || bus.NotZero !== (exp != 0) || bus.JReg !== (op == 4'd10)) begin
        errors++; $display("FAIL flags_op%0d got z=%b nz=%b jr=%b want z=%b nz=%b jr=%b", op,
                           bus.Zero, bus.NotZero, bus.JReg, exp == 0, exp != 0, op == 4'd10);
      end
    end
  endtask

  task automatic test_lw_sw;
    @(posedge clk); #1;
    drive(1'b0, 4'd11, 32'h1000_0FF0, 32'd0);
    bus.Offset = 16'h0014;
    @(negedge clk);
    checks++;
    if (bus.ALUResult !== 32'h0000_0004) begin
      errors++; $display("FAIL lw_pos got %h want 00000004", bus.ALUResult);
    end
    @(posedge clk); #1;
    drive(1'b0, 4'd12, 32'h0000_0010, 32'd0);
    bus.Offset = 16'hFFFC;
    @(negedge clk);
    checks++;
    if (bus.ALUResult !== 32'h0000_000C) begin
      errors++; $display("FAIL sw_neg got %h want 0000000c", bus.ALUResult);
    end
  endtask

  task automatic engine_case(input logic [3:0] op, input logic [31:0] a, b, input int exp_lat);
    int lat;
    logic [31:0] hi, lo, ehi, elo;
    logic busy_after;
    ref_engine(op, a, b, ehi, elo);
    run_engine(op, a, b, lat, hi, lo, busy_after);
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL latency_op%0d got %0d want %0d", op, lat, exp_lat);
    end
    checks++;
    if (hi !== ehi || lo !== elo) begin
      errors++; $display("FAIL hilo_op%0d a=%h b=%h got %h/%h want %h/%h", op, a, b, hi, lo, ehi, elo);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      errors++; $display("FAIL busy_after_op%0d got %b want 0", op, busy_after);
    end
    m_hi = ehi;
    m_lo = elo;
  endtask

  task automatic test_mult;
    engine_case(4'd13, 32'hFFFF_FFFF, 32'd2, LAT);
    @(posedge clk); #1;
    drive(1'b1, 4'd8, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.ALUResult !== m_hi || bus.Stall !== 1'b0) begin
      errors++; $display("FAIL mfhi_after_mult got %h stall=%b want %h stall=0", bus.ALUResult, bus.Stall, m_hi);
    end
    for (int i = 0; i < 5; i++) engine_case(4'd13, $urandom, $urandom, LAT);
    engine_case(4'd13, $urandom, 32'd0, LAT);
  endtask

  task automatic test_div;
    engine_case(4'd14, 32'd100, 32'd7, LAT);
    engine_case(4'd14, 32'd100, 32'd0, 2);
    for (int i = 0; i < 4; i++) engine_case(4'd14, $urandom, 32'($urandom_range(1, 255)), LAT);
    for (int i = 0; i < 3; i++) engine_case(4'd14, $urandom, $urandom | 32'd1, LAT);
    engine_case(4'd14, $urandom, 32'd0, 2);
  endtask

  task automatic test_stall;
    logic [31:0] a, b, x, y, ehi, elo;
    a = $urandom; b = $urandom;
    ref_engine(4'd13, a, b, ehi, elo);
    @(posedge clk); #1;
    drive(1'b1, 4'd13, a, b);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      x = $urandom; y = $urandom;
      if (k == 5) drive(1'b1, 4'd3, x, y);
      else        drive(1'b1, 4'd15, x, y);
      @(negedge clk);
      if (k == 5) begin
        checks++;
        if (bus.Stall !== 1'b0 || bus.ALUResult !== x + y) begin
          errors++; $display("FAIL add_during_busy got %h stall=%b want %h stall=0", bus.ALUResult, bus.Stall, x + y);
        end
      end else begin
        checks++;
        if (bus.Stall !== (k <= LAT)) begin
          errors++; $display("FAIL mflo_stall_k%0d got %b want %b", k, bus.Stall, k <= LAT);
        end
      end
      if (k == LAT + 1) begin
        checks++;
        if (bus.ALUResult !== elo) begin
          errors++; $display("FAIL mflo_result got %h want %h", bus.ALUResult, elo);
        end
      end
    end
    m_hi = ehi; m_lo = elo;
    @(posedge clk); #1;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] a1, b1, a2, b2, h1, l1, h2, l2;
    logic [31:0] hi_mid, lo_mid, hi_end, lo_end;
    int acc_k, d1, d2;
    bit accepted;
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
    ref_engine(4'd13, a1, b1, h1, l1);
    ref_engine(4'd14, a2, b2, h2, l2);
    acc_k = -1; d1 = -1; d2 = -1; accepted = 0;
    hi_mid = 'x; lo_mid = 'x; hi_end = 'x; lo_end = 'x;
    @(posedge clk); #1;
    drive(1'b1, 4'd13, a1, b1);
    for (int k = 1; k <= 2 * LAT + 6; k++) begin
      @(posedge clk); #1;
      if (!accepted) drive(1'b1, 4'd14, a2, b2);
      else           drive(1'b0, 4'd3, a2, b2);
      @(negedge clk);
      if (!accepted && !bus.Stall) begin
        accepted = 1; acc_k = k;
      end
      if (bus.Done) begin
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
      if (k == LAT + 1) begin hi_mid = bus.HI; lo_mid = bus.LO; end
      if (d2 > 0 && k == d2 + 1) begin hi_end = bus.HI; lo_end = bus.LO; end
    end
    checks++;
    if (d1 != LAT || acc_k != LAT + 1) begin
      errors++; $display("FAIL b2b_first got done=%0d accept=%0d want %0d %0d", d1, acc_k, LAT, LAT + 1);
    end
    checks++;
    if (hi_mid !== h1 || lo_mid !== l1) begin
      errors++; $display("FAIL b2b_mult_hilo got %h/%h want %h/%h", hi_mid, lo_mid, h1, l1);
    end
    checks++;
    if (d2 != LAT + 1 + LAT) begin
      errors++; $display("FAIL b2b_second_done got %0d want %0d", d2, 2 * LAT + 1);
    end
    checks++;
    if (hi_end !== h2 || lo_end !== l2) begin
      errors++; $display("FAIL b2b_div_hilo got %h/%h want %h/%h", hi_end, lo_end, h2, l2);
    end
    m_hi = h2; m_lo = l2;
  endtask

  task automatic test_reset_mid;
    int dones;
    engine_case(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT);
    @(posedge clk); #1;
    drive(1'b1, 4'd14, $urandom, 32'($urandom_range(1, 99)));
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      if (k == 10) reset = 1'b0;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      errors++; $display("FAIL mid_reset got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", bus.Busy, bus.Done, bus.HI, bus.LO);
    end
    dones = 0;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(negedge clk);
      if (bus.Done || bus.Busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL mid_reset_activity got %0d want 0", dones);
    end
    m_hi = 0; m_lo = 0;
  endtask

`ifdef ALU_SIGNED_MULDIV_EN
  task automatic test_signed;
    int lat;
    logic [31:0] hi, lo;
    logic busy_after;
    run_engine(4'd13, 32'hFFFF_FFFD, 32'd5, lat, hi, lo, busy_after);
    checks++;
    if (lat != W + 2 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL smult_m3x5 got lat=%0d %h/%h want %0d ffffffff/fffffff1", lat, hi, lo, W + 2);
    end
    run_engine(4'd14, 32'hFFFF_FFF9, 32'd2, lat, hi, lo, busy_after);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL sdiv_m7d2 got %h/%h want ffffffff/fffffffd", hi, lo);
    end
    run_engine(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, lat, hi, lo, busy_after);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      errors++; $display("FAIL sdiv_minneg got %h/%h want 00000000/80000000", hi, lo);
    end
    m_hi = hi; m_lo = lo;
    for (int i = 0; i < 4; i++) engine_case(4'd14, $urandom, 32'($signed($urandom_range(0, 200)) - 100) | 32'd1, LAT);
  endtask
`endif

  initial begin
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    bus.Shamt = '0;
    bus.ProgramCounter = '0;
    bus.Offset = '0;
    test_reset;
    test_single_cycle;
    test_lw_sw;
    test_mult;
    test_div;
    test_stall;
    test_back_to_back;
    test_single_cycle;
    test_reset_mid;
`ifdef ALU_SIGNED_MULDIV_EN
    test_signed;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
